// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6-bit multi-cycle CPU: opcodes, control
// states, instruction layout and datapath widths.
package cpu_pkg;

  localparam int unsigned DATA_W  = 6;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned INSTR_W = 12;

  typedef enum logic [2:0] {
    OP_HALT = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ADI  = 3'b011,
    OP_MUL  = 3'b100,
    OP_CMPJ = 3'b101,
    OP_JMP  = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALTED,
    ST_FAULT
  } state_e;

  typedef struct packed {
    opcode_e           op;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rd;
  } instr_t;

  function automatic logic op_writes(input opcode_e op);
    return (op == OP_LDI) || (op == OP_ADD) || (op == OP_ADI) || (op == OP_MUL);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction-fetch handshake: holds imem_req until imem_valid and flags a
// timeout when the memory leaves the request unanswered too long.
module cpu_fetch_if
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_start,
  input  logic imem_valid,
  output logic imem_req,
  output logic fetch_done,
  output logic fetch_timeout
);

  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Valid on the last allowed waiting cycle wins over the timeout.
  assign fetch_done    = imem_req & imem_valid;
  assign fetch_timeout = imem_req & ~imem_valid & (wait_cnt == CW'(FETCH_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req <= 1'b0;
      wait_cnt <= '0;
    end else if (fetch_start) begin
      imem_req <= 1'b1;
      wait_cnt <= '0;
    end else if (fetch_done || fetch_timeout) begin
      imem_req <= 1'b0;
      wait_cnt <= '0;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: fetch / decode / exec / write-back control, PC and
// retired-instruction bookkeeping for the 6-bit datapath.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter logic [DATA_W-1:0] PC_RESET      = 6'd0,
  parameter int unsigned       FETCH_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 imem_req,
  output logic [DATA_W-1:0]    imem_addr,
  input  logic                 imem_valid,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [2:0]           alu_op,
  output logic [REG_AW-1:0]    rf_ra,
  output logic [REG_AW-1:0]    rf_rb,
  output logic [REG_AW-1:0]    rf_rd,
  output logic                 rf_we,
  input  logic [DATA_W-1:0]    alu_d,
  input  logic                 cmp_ge,
  output logic [DATA_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [7:0]           retired
);

  state_e            state;
  instr_t            ir;
  opcode_e           alu_op_q;
  logic [DATA_W-1:0] res_q;
  logic              ge_q;
  logic              fetch_start;
  logic              fetch_done;
  logic              fetch_timeout;

  assign fetch_start = ((state == ST_IDLE) && start) || (state == ST_WB);

  assign imem_addr = pc;
  assign rf_ra     = ir.ra;
  assign rf_rb     = ir.rb;
  assign rf_rd     = ir.rd;
  assign alu_op    = alu_op_q;

  cpu_fetch_if #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .imem_valid   (imem_valid),
    .imem_req     (imem_req),
    .fetch_done   (fetch_done),
    .fetch_timeout(fetch_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= PC_RESET;
      ir       <= '0;
      alu_op_q <= OP_HALT;
      res_q    <= '0;
      ge_q     <= 1'b0;
      rf_we    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            pc       <= PC_RESET;
            alu_op_q <= OP_NOP;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_done) begin
            ir    <= instr_t'(imem_data);
            state <= ST_DECODE;
          end else if (fetch_timeout) begin
            busy  <= 1'b0;
            fault <= 1'b1;
            state <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          alu_op_q <= ir.op;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q    <= alu_d;
          ge_q     <= cmp_ge;
          alu_op_q <= OP_NOP;
          // HALT retires here since it never reaches write-back.
          if (ir.op == OP_HALT) begin
            busy    <= 1'b0;
            halted  <= 1'b1;
            retired <= sat_inc8(retired);
            state   <= ST_HALTED;
          end else begin
            rf_we <= op_writes(ir.op);
            state <= ST_WB;
          end
        end
        ST_WB: begin
          rf_we <= 1'b0;
          case (ir.op)
            OP_JMP:  pc <= res_q;
            OP_CMPJ: pc <= ge_q ? {3'b000, ir.rd} : pc + 1'b1;
            default: pc <= pc + 1'b1;
          endcase
          retired <= sat_inc8(retired);
          state   <= ST_FETCH;
        end
        ST_HALTED, ST_FAULT: begin
        end
        default: begin
          busy  <= 1'b0;
          fault <= 1'b1;
          state <= ST_FAULT;
        end
      endcase
    end
  end

endmodule
